// File: rtl/fg_reset_pkg.sv
// ----------------------------------------------------------------------------
// fg_reset_pkg
// Shared definitions for the function-generator reset sequencer: the
// sequencer state encoding, default sizing constants and the width of the
// lock-loss event counter.
// ----------------------------------------------------------------------------
package fg_reset_pkg;

  typedef enum logic [2:0] {
    HOLD,
    WAIT_STABLE,
    RELEASE,
    RUN,
    FAULT
  } fg_state_e;

  localparam int NSTAGE_DEF     = 4;
  localparam int STABLE_CYC_DEF = 64;
  localparam int GAP_CYC_DEF    = 16;
  localparam int LOCKCNT_W      = 8;

endpackage

// File: rtl/fg_sync2.sv
// ----------------------------------------------------------------------------
// fg_sync2
// Two flip-flop synchronizer for a single asynchronous level.
// Ports:
//   clk_i  - destination clock
//   rst_i  - asynchronous active-high reset, both flops clear to 0
//   d_i    - asynchronous input level
//   q_o    - synchronized level, two clk_i edges of latency
// ----------------------------------------------------------------------------
module fg_sync2 (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      q_o    <= 1'b0;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/fg_reset_sequencer.sv
// ----------------------------------------------------------------------------
// fg_reset_sequencer
// Staged reset-release sequencer. Synchronizes the generator reset request
// and PLL lock, waits until both have been high for STABLE_CYC cycles, then
// releases the active-low stage resets one at a time, GAP_CYC cycles apart,
// bit 0 first. A reset request returns everything to HOLD; a lock loss once
// releasing has begun enters FAULT for GAP_CYC cycles and is counted.
// Ports:
//   CLK          - system clock
//   RESET        - asynchronous active-high block reset
//   Fg_RESETn    - generator reset request, active-low, asynchronous
//   PllLocked    - PLL lock indicator, asynchronous
//   StageRESETn  - per-stage active-low resets (registered)
//   SeqDone      - high while every stage is released (registered)
//   LockLossCnt  - saturating count of lock-loss events (registered)
// ----------------------------------------------------------------------------
module fg_reset_sequencer
  import fg_reset_pkg::*;
#(
  parameter int NSTAGE     = NSTAGE_DEF,
  parameter int STABLE_CYC = STABLE_CYC_DEF,
  parameter int GAP_CYC    = GAP_CYC_DEF
) (
  input  logic                 CLK,
  input  logic                 RESET,
  input  logic                 Fg_RESETn,
  input  logic                 PllLocked,
  output logic [NSTAGE-1:0]    StageRESETn,
  output logic                 SeqDone,
  output logic [LOCKCNT_W-1:0] LockLossCnt
);

  localparam int STAB_W = $clog2(STABLE_CYC) + 1;
  localparam int GAP_W  = $clog2(GAP_CYC) + 1;
  localparam int IDX_W  = $clog2(NSTAGE) + 1;

  logic rstn_s;
  logic lock_s;

  fg_sync2 u_sync_rstn (
    .clk_i (CLK),
    .rst_i (RESET),
    .d_i   (Fg_RESETn),
    .q_o   (rstn_s)
  );

  fg_sync2 u_sync_lock (
    .clk_i (CLK),
    .rst_i (RESET),
    .d_i   (PllLocked),
    .q_o   (lock_s)
  );

  fg_state_e             state_q, state_d;
  logic [STAB_W-1:0]     stab_q, stab_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NSTAGE-1:0]     stage_q, stage_d;
  logic                  done_q, done_d;
  logic [LOCKCNT_W-1:0]  llc_q, llc_d;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= HOLD;
      stab_q  <= '0;
      gap_q   <= '0;
      idx_q   <= '0;
      stage_q <= '0;
      done_q  <= 1'b0;
      llc_q   <= '0;
    end else begin
      state_q <= state_d;
      stab_q  <= stab_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      done_q  <= done_d;
      llc_q   <= llc_d;
    end
  end

  // gap_q is a down-counter shared by RELEASE (cycles to next release) and
  // FAULT (remaining hold); zero on RELEASE entry releases bit 0 at once.
  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    done_d  = done_q;
    llc_d   = llc_q;

    unique case (state_q)
      HOLD: begin
        stage_d = '0;
        done_d  = 1'b0;
        if (rstn_s && lock_s) begin
          state_d = WAIT_STABLE;
          stab_d  = '0;
        end
      end

      WAIT_STABLE: begin
        if (!(rstn_s && lock_s)) begin
          state_d = HOLD;
        end else if (stab_q == STAB_W'(STABLE_CYC - 1)) begin
          state_d = RELEASE;
          idx_d   = '0;
          gap_d   = '0;
        end else begin
          stab_d = stab_q + STAB_W'(1);
        end
      end

      RELEASE, RUN: begin
        // A reset request wins over a simultaneous lock loss and is not counted.
        if (!rstn_s) begin
          state_d = HOLD;
          stage_d = '0;
          done_d  = 1'b0;
        end else if (!lock_s) begin
          state_d = FAULT;
          stage_d = '0;
          done_d  = 1'b0;
          gap_d   = GAP_W'(GAP_CYC - 1);
          if (llc_q != '1) begin
            llc_d = llc_q + LOCKCNT_W'(1);
          end
        end else if (state_q == RELEASE) begin
          if (gap_q == '0) begin
            for (int k = 0; k < NSTAGE; k++) begin
              if (idx_q == IDX_W'(k)) begin
                stage_d[k] = 1'b1;
              end
            end
            if (idx_q == IDX_W'(NSTAGE - 1)) begin
              state_d = RUN;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + IDX_W'(1);
              gap_d = GAP_W'(GAP_CYC - 1);
            end
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
      end

      FAULT: begin
        // Hold is fixed length; a reset request cannot shorten it.
        stage_d = '0;
        done_d  = 1'b0;
        if (gap_q == '0) begin
          state_d = HOLD;
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end

      default: begin
        state_d = HOLD;
        stage_d = '0;
        done_d  = 1'b0;
      end
    endcase
  end

  assign StageRESETn = stage_q;
  assign SeqDone     = done_q;
  assign LockLossCnt = llc_q;

endmodule
